// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the hazard/stall controller.
//   state_e        : FSM encoding (RUN, MC_BUSY)
//   MC_LATENCY_DEF : default multi-cycle op occupancy of EX, in cycles
//   REG_X0         : architectural zero register index
package hazard_stall_controller_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

  localparam int         MC_LATENCY_DEF = 4;
  localparam logic [4:0] REG_X0         = 5'd0;

endpackage

// File: rtl/hazard_stall_controller_load_use_detect.sv
// Combinational load-use hazard comparator.
//   rs1_i/rs2_i        : source registers of the ID instruction
//   uses_rs1_i/rs2_i   : ID instruction really reads that source
//   rd_i, mem_read_i   : destination / load flag of the EX instruction
//   hazard_o           : forwarding cannot cover this, a stall is needed
module load_use_detect
  import hazard_stall_controller_pkg::*;
(
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       uses_rs1_i,
  input  logic       uses_rs2_i,
  input  logic [4:0] rd_i,
  input  logic       mem_read_i,
  output logic       hazard_o
);

  logic match1, match2;

  assign match1   = uses_rs1_i && (rs1_i == rd_i);
  assign match2   = uses_rs2_i && (rs2_i == rd_i);
  // x0 is never a real producer, so a load targeting it cannot create a hazard
  assign hazard_o = mem_read_i && (rd_i != REG_X0) && (match1 || match2);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage core.
// Inputs : ID source regs/uses, EX rd/load flag, branch-taken, multi-cycle start.
// Outputs: PC/IF_ID/ID_EX write enables, IF_ID flush, ID_EX/EX_MEM bubbles,
//          Busy (FSM in MC_BUSY), saturating StallCount and FlushCount.
// Control outputs are Mealy; state, cnt and counters are registered.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MC_LATENCY = MC_LATENCY_DEF,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           IF_ID_RegisterRs1,
  input  logic [4:0]           IF_ID_RegisterRs2,
  input  logic                 IF_ID_UsesRs1,
  input  logic                 IF_ID_UsesRs2,
  input  logic [4:0]           ID_EX_RegisterRd,
  input  logic                 ID_EX_MemRead,
  input  logic                 EX_BranchTaken,
  input  logic                 EX_MultiCycleStart,
  output logic                 PCWrite,
  output logic                 IF_ID_Write,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Write,
  output logic                 ID_EX_Bubble,
  output logic                 EX_MEM_Bubble,
  output logic                 Busy,
  output logic [CNT_WIDTH-1:0] StallCount,
  output logic [CNT_WIDTH-1:0] FlushCount
);

  localparam int CW = $clog2(MC_LATENCY);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 load_use;
  logic                 flush_evt;

  load_use_detect u_lud (
    .rs1_i      (IF_ID_RegisterRs1),
    .rs2_i      (IF_ID_RegisterRs2),
    .uses_rs1_i (IF_ID_UsesRs1),
    .uses_rs2_i (IF_ID_UsesRs2),
    .rd_i       (ID_EX_RegisterRd),
    .mem_read_i (ID_EX_MemRead),
    .hazard_o   (load_use)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Write   = 1'b1;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Bubble = 1'b0;
    flush_evt     = 1'b0;
    // reset overrides the decode so outputs go to defaults in the same cycle
    if (!reset) begin
      unique case (state_q)
        RUN: begin
          if (EX_BranchTaken) begin
            // younger instructions are squashed, so any load-use is moot
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            flush_evt    = 1'b1;
          end else if (EX_MultiCycleStart) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
            state_d       = MC_BUSY;
            cnt_d         = CW'(MC_LATENCY - 2);
          end else if (load_use) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
          end
        end
        MC_BUSY: begin
          if (cnt_q != '0) begin
            PCWrite       = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Bubble = 1'b1;
            cnt_d         = cnt_q - 1'b1;
          end else begin
            // final EX cycle of the op: release the pipeline
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!PCWrite && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign Busy       = (state_q == MC_BUSY) && !reset;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    rs1 = '0, rs2 = '0, rd = '0;
  logic          u1 = 1'b0, u2 = 1'b0, mrd = 1'b0, br = 1'b0, mcs = 1'b0;
  logic          PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write;
  logic          ID_EX_Bubble, EX_MEM_Bubble, Busy;
  logic [CW-1:0] StallCount, FlushCount;

  int total = 0;
  int passed = 0;

  hazard_stall_controller #(.MC_LATENCY(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2),
    .IF_ID_UsesRs1(u1), .IF_ID_UsesRs2(u2),
    .ID_EX_RegisterRd(rd), .ID_EX_MemRead(mrd),
    .EX_BranchTaken(br), .EX_MultiCycleStart(mcs),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .EX_MEM_Bubble(EX_MEM_Bubble), .Busy(Busy),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  // packed view of control outputs: {PCW, IFW, IFF, IDW, IDB, EMB, Busy}
  function automatic logic [6:0] ctl();
    return {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble, Busy};
  endfunction

  localparam logic [6:0] DEF    = 7'b1101000;
  localparam logic [6:0] LU     = 7'b0001100;
  localparam logic [6:0] BRF    = 7'b1111100;
  localparam logic [6:0] MC0    = 7'b0000010;
  localparam logic [6:0] MCB    = 7'b0000011;
  localparam logic [6:0] REL    = 7'b1101001;

  task automatic idle();
    rs1 = '0; rs2 = '0; rd = '0; u1 = 0; u2 = 0; mrd = 0; br = 0; mcs = 0;
  endtask

  // inputs change at the negedge, outputs sampled 1 time unit later
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_ctl(input string name, input logic [6:0] exp);
    #1;
    total++;
    if (ctl() !== exp) $display("FAIL %s: ctl got %b expected %b", name, ctl(), exp);
    else passed++;
  endtask

  task automatic chk_cnt(input string name, input logic [CW-1:0] es, input logic [CW-1:0] ef);
    total++;
    if (StallCount !== es || FlushCount !== ef)
      $display("FAIL %s: stall/flush got %0d/%0d expected %0d/%0d", name, StallCount, FlushCount, es, ef);
    else passed++;
  endtask

  task automatic test_reset();
    #2;
    chk_ctl("reset_outputs", DEF);
    chk_cnt("reset_counts", 0, 0);
    @(negedge clk);
    reset = 1'b0;
    chk_ctl("post_reset_idle", DEF);
  endtask

  task automatic test_load_use();
    do_reset();
    rd = 5; mrd = 1; rs1 = 5; u1 = 1;
    chk_ctl("lu_rs1_stall", LU);
    next_cycle();
    mrd = 0;
    chk_ctl("lu_released", DEF);
    chk_cnt("lu_count", 1, 0);
    rd = 7; mrd = 1; rs1 = 1; u1 = 1; rs2 = 7; u2 = 1;
    chk_ctl("lu_rs2_stall", LU);
    next_cycle();
    idle();
    chk_cnt("lu_rs2_count", 2, 0);
  endtask

  task automatic test_no_false_stall();
    do_reset();
    rd = 0; mrd = 1; rs1 = 0; u1 = 1;
    chk_ctl("nfs_x0", DEF);
    next_cycle();
    rd = 5; mrd = 1; rs1 = 3; u1 = 1; rs2 = 5; u2 = 0;
    chk_ctl("nfs_rs2_unused", DEF);
    next_cycle();
    rd = 5; mrd = 0; rs1 = 5; u1 = 1;
    chk_ctl("nfs_not_load", DEF);
    next_cycle();
    idle();
    chk_cnt("nfs_count", 0, 0);
  endtask

  task automatic test_branch_over_load_use();
    do_reset();
    br = 1; rd = 5; mrd = 1; rs1 = 5; u1 = 1;
    chk_ctl("br_lu_flush", BRF);
    next_cycle();
    idle();
    chk_cnt("br_lu_count", 0, 1);
    chk_ctl("br_after", DEF);
  endtask

  task automatic test_multicycle();
    do_reset();
    mcs = 1;
    chk_ctl("mc_c1", MC0);
    next_cycle();
    // inputs in MC_BUSY must be ignored
    mcs = 0; br = 1; rd = 5; mrd = 1; rs1 = 5; u1 = 1;
    chk_ctl("mc_c2", MCB);
    next_cycle();
    chk_ctl("mc_c3", MCB);
    next_cycle();
    chk_ctl("mc_c4_release", REL);
    next_cycle();
    idle();
    chk_ctl("mc_c5_run", DEF);
    chk_cnt("mc_count", 3, 0);
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    mcs = 1;
    next_cycle();
    mcs = 0;
    next_cycle();
    chk_ctl("rmb_busy_cnt1", MCB);
    reset = 1'b1;
    chk_ctl("rmb_reset_now", DEF);
    chk_cnt("rmb_counts_zero", 0, 0);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    chk_ctl("rmb_run_after", DEF);
    chk_cnt("rmb_counts_after", 0, 0);
  endtask

  task automatic test_saturation();
    do_reset();
    rd = 9; mrd = 1; rs2 = 9; u2 = 1;
    repeat (20) next_cycle();
    chk_ctl("sat_still_stall", LU);
    chk_cnt("sat_stall15", 15, 0);
    idle();
    br = 1;
    repeat (20) next_cycle();
    idle();
    chk_cnt("sat_flush15", 15, 15);
  endtask

  initial begin
    fork
      begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
      end
    join_none
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_branch_over_load_use();
    test_multicycle();
    test_reset_mid_busy();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
